display_scan_ctrl: RTL and testbench

//  Time-multiplexes NUM_DIGITS packed BCD digits through one shared 7-seg decoder.

---
 rtl/display_scan_ctrl.sv | 161 ++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Scans NUM_DIGITS packed BCD digits through one shared 7-seg decoder, with a
// ghosting blank before every dwell, frame-boundary double buffering and leading-zero blanking.
module display_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_load_value,
  input  logic                    i_lz_blank,
  output logic                    o_load_ack,
  output logic [3:0]              o_dec_digit,
  output logic [NUM_DIGITS-1:0]   o_an_n,
  output logic                    o_frame_done
);

  localparam int unsigned W  = 4 * NUM_DIGITS;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DWELL} state_t;

  state_t                r_state;
  logic [IW-1:0]         r_idx;
  logic [CNT_W-1:0]      r_timer;
  logic [W-1:0]          r_shadow;
  logic [W-1:0]          r_active;
  logic                  r_pending;
  logic                  r_load_ack;
  logic [3:0]            r_dec;
  logic [NUM_DIGITS-1:0] r_an_n;
  logic                  r_frame_done;

  logic          w_blank_end;
  logic          w_dwell_end;
  logic          w_last;
  logic          w_boundary;
  logic          w_copy;
  logic [IW-1:0] w_idx_inc;
  logic [W-1:0]  w_active_nxt;

  // Digit idx is suppressed when it and every more significant digit are zero.
  function automatic logic f_blanked(input logic [W-1:0] v, input logic [IW-1:0] idx,
                                     input logic lz);
    logic z;
    z = lz && (idx != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(idx)) && (v[4*i +: 4] != 4'h0)) z = 1'b0;
    end
    return z;
  endfunction

  function automatic logic [3:0] f_dec(input logic [W-1:0] v, input logic [IW-1:0] idx,
                                       input logic lz);
    return f_blanked(v, idx, lz) ? 4'hF : v[4*int'(idx) +: 4];
  endfunction

  function automatic logic [NUM_DIGITS-1:0] f_an(input logic [W-1:0] v,
                                                 input logic [IW-1:0] idx, input logic lz);
    logic [NUM_DIGITS-1:0] a;
    a = '1;
    if (!f_blanked(v, idx, lz)) a[idx] = 1'b0;
    return a;
  endfunction

  assign w_blank_end  = (r_timer == CNT_W'(BLANK_CYCLES - 1));
  assign w_dwell_end  = (r_timer == CNT_W'(DWELL_CYCLES - 1));
  assign w_last       = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_idx_inc    = w_last ? '0 : r_idx + IW'(1);
  assign w_boundary   = (r_state == S_DWELL) && i_en && w_dwell_end && w_last;
  // Shadow reaches the display only while idle or across a frame boundary.
  assign w_copy       = r_pending && ((r_state == S_IDLE) || w_boundary);
  assign w_active_nxt = w_copy ? r_shadow : r_active;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_timer      <= '0;
      r_shadow     <= '0;
      r_active     <= '0;
      r_pending    <= 1'b0;
      r_load_ack   <= 1'b0;
      r_dec        <= 4'hF;
      r_an_n       <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_load_ack   <= i_load;
      r_frame_done <= 1'b0;
      if (w_copy) r_active <= r_shadow;
      if (i_load) begin
        r_shadow  <= i_load_value;
        r_pending <= 1'b1;
      end else if (w_copy) begin
        r_pending <= 1'b0;
      end

      case (r_state)
        S_BLANK: begin
          if (!i_en) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_timer <= '0;
            r_an_n  <= '1;
            r_dec   <= 4'hF;
          end else if (w_blank_end) begin
            r_state <= S_DWELL;
            r_timer <= '0;
            r_an_n  <= f_an(w_active_nxt, r_idx, i_lz_blank);
            r_dec   <= f_dec(w_active_nxt, r_idx, i_lz_blank);
          end else begin
            r_timer <= r_timer + CNT_W'(1);
            r_an_n  <= '1;
            r_dec   <= f_dec(w_active_nxt, r_idx, i_lz_blank);
          end
        end
        S_DWELL: begin
          if (!i_en) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_timer <= '0;
            r_an_n  <= '1;
            r_dec   <= 4'hF;
          end else if (w_dwell_end) begin
            r_state      <= S_BLANK;
            r_idx        <= w_idx_inc;
            r_timer      <= '0;
            r_frame_done <= w_last;
            r_an_n       <= '1;
            r_dec        <= f_dec(w_active_nxt, w_idx_inc, i_lz_blank);
          end else begin
            r_timer <= r_timer + CNT_W'(1);
            r_an_n  <= f_an(w_active_nxt, r_idx, i_lz_blank);
            r_dec   <= f_dec(w_active_nxt, r_idx, i_lz_blank);
          end
        end
        default: begin
          r_idx   <= '0;
          r_timer <= '0;
          r_an_n  <= '1;
          if (i_en) begin
            r_state <= S_BLANK;
            r_dec   <= f_dec(w_active_nxt, '0, i_lz_blank);
          end else begin
            r_state <= S_IDLE;
            r_dec   <= 4'hF;
          end
        end
      endcase
    end
  end

  assign o_load_ack   = r_load_ack;
  assign o_dec_digit  = r_dec;
  assign o_an_n       = r_an_n;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: frame-position reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_display_scan_ctrl;

  localparam int N     = 4;
  localparam int DW    = 4;
  localparam int BL    = 2;
  localparam int SLOT  = BL + DW;
  localparam int FRAME = N * SLOT;

  logic        clk = 1'b0;
  logic        rst_n, en, load, lz;
  logic [15:0] lv;
  logic        load_ack, frame_done;
  logic [3:0]  dec_digit, an_n;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: scan position within the frame instead of a state machine.
  bit          m_run;
  int          m_pos;
  logic [15:0] m_shadow, m_active;
  bit          m_pend;
  logic [3:0]  e_dec, e_an;
  bit          e_ack, e_fd;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .NUM_DIGITS(N), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL), .CNT_W(16)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_load(load), .i_load_value(lv),
    .i_lz_blank(lz), .o_load_ack(load_ack), .o_dec_digit(dec_digit), .o_an_n(an_n),
    .o_frame_done(frame_done)
  );

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit          fend, cp, in_blank, hide;
    int          d;
    logic [15:0] upper;
    if (!rst_n) begin
      m_run = 0; m_pos = 0; m_shadow = '0; m_active = '0; m_pend = 0;
      e_ack = 0; e_fd = 0; e_an = 4'hF; e_dec = 4'hF;
      return;
    end
    fend = m_run && en && (m_pos == FRAME - 1);
    cp   = m_pend && (!m_run || fend);
    if (cp) m_active = m_shadow;
    if (load) begin
      m_shadow = lv;
      m_pend   = 1;
    end else if (cp) begin
      m_pend = 0;
    end
    e_ack = load;
    e_fd  = fend;
    if (!m_run) begin
      if (en) begin m_run = 1; m_pos = 0; end
    end else if (!en) begin
      m_run = 0;
    end else begin
      m_pos = (m_pos + 1) % FRAME;
    end
    if (!m_run) begin
      e_an = 4'hF; e_dec = 4'hF;
    end else begin
      d        = m_pos / SLOT;
      in_blank = (m_pos % SLOT) < BL;
      upper    = m_active >> (4 * d);
      hide     = lz && (d > 0) && (upper == 16'h0);
      e_dec    = hide ? 4'hF : upper[3:0];
      e_an     = (in_blank || hide) ? 4'hF : ~(4'b0001 << d);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model_an_n", 16'(an_n), 16'(e_an));
    check("model_dec_digit", 16'(dec_digit), 16'(e_dec));
    check("model_load_ack", 16'(load_ack), 16'(e_ack));
    check("model_frame_done", 16'(frame_done), 16'(e_fd));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst_n = 0; en = 0; load = 0; lz = 0; lv = '0;
    run(3);
    check("reset_an_n", 16'(an_n), 16'hF);
    check("reset_dec", 16'(dec_digit), 16'hF);
    check("reset_fd", 16'(frame_done), 16'h0);
    check("reset_ack", 16'(load_ack), 16'h0);

    // Load 1234 while idle, then scan.
    rst_n = 1; lv = 16'h1234; load = 1;
    cycle();
    check("idle_ack", 16'(load_ack), 16'h1);
    load = 0;
    run(2);
    en = 1;
    cycle();                                    // k=1 first blank cycle
    check("k1_an", 16'(an_n), 16'hF);
    run(2);                                     // k=3 digit 0 dwell
    check("k3_an", 16'(an_n), 16'hE);
    check("k3_dec", 16'(dec_digit), 16'h4);
    run(6);                                     // k=9 digit 1 dwell
    check("k9_an", 16'(an_n), 16'hD);
    check("k9_dec", 16'(dec_digit), 16'h3);
    lv = 16'h5678; load = 1;
    cycle();                                    // k=10
    check("mid_ack", 16'(load_ack), 16'h1);
    load = 0;
    run(11);                                    // k=21 digit 3 dwell, still old value
    check("k21_an", 16'(an_n), 16'h7);
    check("k21_dec", 16'(dec_digit), 16'h1);
    run(4);                                     // k=25 frame boundary
    check("k25_fd", 16'(frame_done), 16'h1);
    check("k25_dec_new", 16'(dec_digit), 16'h8);
    lv = 16'h9999; load = 1;                    // load on the frame_done cycle
    cycle();
    check("k26_fd", 16'(frame_done), 16'h0);
    load = 0;
    cycle();                                    // k=27
    check("k27_dec_old", 16'(dec_digit), 16'h8);
    check("k27_an", 16'(an_n), 16'hE);
    run(22);                                    // k=49
    check("k49_fd", 16'(frame_done), 16'h1);
    check("k49_dec_9999", 16'(dec_digit), 16'h9);

    // Reset mid-dwell, then restart.
    run(3);
    rst_n = 0;
    cycle();
    check("rstmid_an", 16'(an_n), 16'hF);
    check("rstmid_dec", 16'(dec_digit), 16'hF);
    check("rstmid_fd", 16'(frame_done), 16'h0);
    run(2);
    rst_n = 1;
    run(3);
    check("restart_an", 16'(an_n), 16'hE);
    check("restart_dec", 16'(dec_digit), 16'h0);

    // Leading-zero blanking on 0070.
    en = 0; lz = 1; lv = 16'h0070; load = 1;
    cycle();
    load = 0;
    cycle();
    en = 1;
    run(3);
    check("lz_d0_an", 16'(an_n), 16'hE);
    check("lz_d0_dec", 16'(dec_digit), 16'h0);
    run(6);
    check("lz_d1_an", 16'(an_n), 16'hD);
    check("lz_d1_dec", 16'(dec_digit), 16'h7);
    run(6);                                     // digit 2 dwell slot
    check("lz_d2_an", 16'(an_n), 16'hF);
    check("lz_d2_dec", 16'(dec_digit), 16'hF);

    // Drop enable during digit 2 dwell.
    en = 0;
    cycle();
    check("drop_an", 16'(an_n), 16'hF);
    check("drop_fd", 16'(frame_done), 16'h0);
    en = 1;
    cycle();
    check("reen_blank_an", 16'(an_n), 16'hF);
    run(2);
    check("reen_d0_an", 16'(an_n), 16'hE);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      en    = ($urandom_range(0, 39) != 0);
      load  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) lz = ~lz;
      for (int i = 0; i < N; i++)
        lv[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
